// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction width, canonical NOP and loader state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;

  // add $0,$0,$0 -- the padding word for every unused instruction slot
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_DONE,
    ST_ERR,
    ST_CKSUM
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready instruction stream into the loader; the source is master, the loader is slave.
interface imem_loader_if #(
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: stores a word stream from address 0, NOP-pads the rest, then releases the CPU.
// Define IMEM_LOADER_CKSUM_EN to treat the s_last word as a mod-2^32 checksum of the written image.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   r_count;
  logic              w_xfer;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  assign w_xfer = s.valid && r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Status flags settle one cycle after the final write; a start overrides them below
          if (r_state == ST_DONE) begin
            r_cpu_rst <= 1'b0;
            r_done    <= 1'b1;
          end
          if (r_state == ST_ERR) begin
            r_err <= 1'b1;
          end
          if (start) begin
            r_state   <= ST_LOAD;
            r_ready   <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_count   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_sum     <= '0;
`endif
          end
        end

        ST_LOAD: begin
          if (w_xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
            if (s.last) begin
              // Checksum word is not stored; padding starts at its would-be address
              r_ready <= 1'b0;
              r_state <= (s.data == r_sum) ? ST_FILL : ST_ERR;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= s.data;
              r_addr  <= r_addr + 1'b1;
              r_count <= r_count + 1'b1;
              r_sum   <= r_sum + s.data;
              if (r_addr == LAST_ADDR) begin
                r_state <= ST_CKSUM;
              end
            end
`else
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= s.data;
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
            if (s.last) begin
              r_ready <= 1'b0;
              r_state <= (r_addr == LAST_ADDR) ? ST_DONE : ST_FILL;
            end else if (r_addr == LAST_ADDR) begin
              r_ready <= 1'b0;
              r_state <= ST_ERR;
            end
`endif
          end
        end

        ST_FILL: begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= DATA_W'(NOP_INSTR);
          r_addr  <= r_addr + 1'b1;
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_DONE;
          end
        end

`ifdef IMEM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          // Memory is full; only a matching checksum word can complete the load
          if (w_xfer) begin
            r_ready <= 1'b0;
            r_state <= (s.last && (s.data == r_sum)) ? ST_DONE : ST_ERR;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s.ready    = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_count;

endmodule
